// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory controller: length encodings, owner tag and
// the request fields latched at acceptance.
package mem_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [2:0] LEN_B = 3'b001;
  localparam logic [2:0] LEN_H = 3'b010;
  localparam logic [2:0] LEN_W = 3'b100;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e              owner;
    logic [1:0]          last;  // index of the final byte (N-1)
    logic [DATA_W-1:0]   data;
  } req_t;

  // Unsupported length codes fall back to a full word.
  function automatic logic [1:0] len_last(input logic [2:0] len);
    case (len)
      LEN_B:   return 2'd0;
      LEN_H:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and mem-stage requests onto a byte-wide synchronous RAM,
// serialising word/half/byte accesses into single-byte RAM cycles.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_require_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_busy_o,
  output logic              if_enable_o,
  output logic [31:0]       if_data_o,
  input  logic              mem_require_i,
  input  logic              mem_wr_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [2:0]        mem_length_i,
  input  logic [31:0]       mem_data_i,
  output logic              mem_busy_o,
  output logic              mem_enable_o,
  output logic [31:0]       mem_data_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q;
  req_t                req_q;
  logic [1:0]          cnt_q;
  logic                tail_q;
  logic [DATA_W-1:0]   asm_q;
  logic                busy_q;
  logic                if_en_q;
  logic                mem_en_q;
  logic [DATA_W-1:0]   if_data_q;
  logic [DATA_W-1:0]   mem_data_q;
  logic [ADDR_W-1:0]   ram_a_q;
  logic [BYTE_W-1:0]   ram_dout_q;
  logic                ram_wr_q;

  logic [1:0]          cap_idx_d;
  logic                cap_en_d;
  logic [DATA_W-1:0]   asm_d;
  logic [BYTE_W-1:0]   wr_byte_d;

  // RAM data lags its address by one cycle, so capture trails issue by one byte.
  always_comb begin
    cap_idx_d = tail_q ? req_q.last : (cnt_q - 2'd1);
    cap_en_d  = (state_q == S_READ) && (tail_q || (cnt_q != 2'd0));
    asm_d     = asm_q;
    for (int j = 0; j < 4; j++) begin
      if (cap_idx_d == 2'(j)) asm_d[8*j +: 8] = ram_din_i;
    end
  end

  assign wr_byte_d = 8'(req_q.data >> {cnt_q + 2'd1, 3'b000});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      cnt_q      <= '0;
      tail_q     <= 1'b0;
      asm_q      <= '0;
      busy_q     <= 1'b0;
      if_en_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      if_data_q  <= '0;
      mem_data_q <= '0;
      ram_a_q    <= '0;
      ram_dout_q <= '0;
      ram_wr_q   <= 1'b0;
    end else begin
      if_en_q  <= 1'b0;
      mem_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_require_i || if_require_i) begin
            req_q <= '{owner: (mem_require_i ? OWN_MEM : OWN_IF),
                       last:  (mem_require_i ? len_last(mem_length_i) : 2'd3),
                       data:  mem_data_i};
            ram_a_q <= mem_require_i ? mem_addr_i : if_addr_i;
            cnt_q   <= '0;
            tail_q  <= 1'b0;
            asm_q   <= '0;
            busy_q  <= 1'b1;
            if (mem_require_i && mem_wr_i) begin
              state_q    <= S_WRITE;
              ram_wr_q   <= 1'b1;
              ram_dout_q <= mem_data_i[7:0];
            end else begin
              state_q <= S_READ;
            end
          end
        end
        S_READ: begin
          if (cap_en_d) asm_q <= asm_d;
          if (tail_q) begin
            state_q <= S_DONE;
            if (req_q.owner == OWN_MEM) begin
              mem_en_q   <= 1'b1;
              mem_data_q <= asm_d;
            end else begin
              if_en_q   <= 1'b1;
              if_data_q <= asm_d;
            end
          end else if (cnt_q == req_q.last) begin
            tail_q  <= 1'b1;
            ram_a_q <= '0;
          end else begin
            cnt_q   <= cnt_q + 2'd1;
            ram_a_q <= ram_a_q + ADDR_W'(1);
          end
        end
        S_WRITE: begin
          if (cnt_q == req_q.last) begin
            state_q    <= S_DONE;
            ram_wr_q   <= 1'b0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            mem_en_q   <= 1'b1;
          end else begin
            cnt_q      <= cnt_q + 2'd1;
            ram_a_q    <= ram_a_q + ADDR_W'(1);
            ram_dout_q <= wr_byte_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_busy_o    = busy_q;
  assign mem_busy_o   = busy_q;
  assign if_enable_o  = if_en_q;
  assign mem_enable_o = mem_en_q;
  assign if_data_o    = if_data_q;
  assign mem_data_o   = mem_data_q;
  assign ram_a_o      = ram_a_q;
  assign ram_dout_o   = ram_dout_q;
  assign ram_wr_o     = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised bench for mem_ctrl: a byte RAM, a per-cycle expectation table
// built from the transaction rules, and directed literal checks.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_require_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_busy_o, if_enable_o;
  logic [31:0] if_data_o;
  logic        mem_require_i = 1'b0;
  logic        mem_wr_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [2:0]  mem_length_i = '0;
  logic [31:0] mem_data_i = '0;
  logic        mem_busy_o, mem_enable_o;
  logic [31:0] mem_data_o;
  logic [7:0]  ram_din_i = '0;
  logic [7:0]  ram_dout_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_require_i(if_require_i), .if_addr_i(if_addr_i),
    .if_busy_o(if_busy_o), .if_enable_o(if_enable_o), .if_data_o(if_data_o),
    .mem_require_i(mem_require_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i),
    .mem_length_i(mem_length_i), .mem_data_i(mem_data_i),
    .mem_busy_o(mem_busy_o), .mem_enable_o(mem_enable_o), .mem_data_o(mem_data_o),
    .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram[logic [31:0]];
  logic [7:0] mdl[logic [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction
  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : dflt(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    mdl[a] = b;
  endtask

  // Synchronous byte RAM: read data appears the cycle after its address.
  always @(posedge clk) begin
    if (!$isunknown(ram_a_o)) begin
      ram_din_i <= ram_rd(ram_a_o);
      if (ram_wr_o === 1'b1) ram[ram_a_o] = ram_dout_o;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    bit          busy;
    bit          wr;
    bit          chk_a;
    bit          chk_d;
    bit          if_en;
    bit          mem_en;
    bit          ld;
    bit          rst_ev;
    logic [31:0] a;
    logic [31:0] data;
    logic [7:0]  dout;
  } exp_t;

  exp_t exp_tab[int];
  exp_t ce;
  logic [31:0] held_if = '0;
  logic [31:0] held_mem = '0;

  function automatic exp_t idle_exp();
    exp_t e;
    e.busy = 0; e.wr = 0; e.chk_a = 1; e.chk_d = 1; e.if_en = 0; e.mem_en = 0;
    e.ld = 0; e.rst_ev = 0; e.a = '0; e.data = '0; e.dout = '0;
    return e;
  endfunction

  // Per-cycle comparison of every output against the expectation table.
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      ce = exp_tab.exists(cyc) ? exp_tab[cyc] : idle_exp();
      if (ce.rst_ev) begin
        held_if  = '0;
        held_mem = '0;
      end
      if (ce.ld && ce.if_en) held_if = ce.data;
      if (ce.ld && ce.mem_en) held_mem = ce.data;
      chk("if_busy", 32'(if_busy_o), 32'(ce.busy));
      chk("mem_busy", 32'(mem_busy_o), 32'(ce.busy));
      chk("ram_wr", 32'(ram_wr_o), 32'(ce.wr));
      if (ce.chk_a) chk("ram_a", ram_a_o, ce.a);
      if (ce.chk_d) chk("ram_dout", 32'(ram_dout_o), 32'(ce.dout));
      chk("if_enable", 32'(if_enable_o), 32'(ce.if_en));
      chk("mem_enable", 32'(mem_enable_o), 32'(ce.mem_en));
      chk("if_data", if_data_o, held_if);
      chk("mem_data", mem_data_o, held_mem);
    end
  end

  task automatic goto_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive one request in the current idle cycle and record what every
  // following cycle must look like. abort>0 models a reset after that cycle.
  task automatic issue(input bit is_mem, input bit wr_in, input logic [31:0] addr,
                       input logic [2:0] len, input logic [31:0] data, input int abort,
                       output int c0, output int last);
    int n;
    bit wr;
    exp_t e;
    logic [31:0] rd;
    logic [31:0] ba;
    wr = is_mem && wr_in;
    n = (is_mem && (len == 3'd1 || len == 3'd2)) ? int'(len) : 4;
    c0 = cyc;
    if (is_mem) begin
      mem_require_i = 1'b1; mem_wr_i = wr; mem_addr_i = addr;
      mem_length_i = len; mem_data_i = data;
    end else begin
      if_require_i = 1'b1; if_addr_i = addr; mem_wr_i = 1'b0;
    end
    rd = '0;
    for (int k = 1; k <= n; k++) begin
      if (abort == 0 || k <= abort) begin
        ba = addr + 32'(k - 1);
        e = idle_exp();
        e.busy = 1; e.a = ba;
        if (wr) begin
          e.wr = 1; e.dout = data[8*(k-1) +: 8];
          mdl[ba] = data[8*(k-1) +: 8];
        end else begin
          e.chk_d = 0;
          rd[8*(k-1) +: 8] = mdl_rd(ba);
        end
        exp_tab[c0 + k] = e;
      end
    end
    e = idle_exp();
    if (abort != 0) begin
      e.rst_ev = 1;
      exp_tab[c0 + abort + 1] = e;
      last = abort + 1;
    end else if (wr) begin
      e.busy = 1; e.chk_a = 0; e.chk_d = 0; e.mem_en = 1;
      exp_tab[c0 + n + 1] = e;
      last = n + 1;
    end else begin
      e.busy = 1; e.chk_a = 0; e.chk_d = 0;
      exp_tab[c0 + n + 1] = e;
      e.mem_en = is_mem; e.if_en = !is_mem; e.ld = 1; e.data = rd;
      exp_tab[c0 + n + 2] = e;
      last = n + 2;
    end
    @(negedge clk);
    if (is_mem) mem_require_i = 1'b0;
    else if_require_i = 1'b0;
    mem_wr_i = 1'($urandom); mem_addr_i = $urandom;
    mem_length_i = 3'($urandom); mem_data_i = $urandom;
  endtask

  initial begin
    int c0, c1, last;
    logic [31:0] a;
    bit is_mem;

    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    preload(32'h202, 8'h77);
    preload(32'h10, 8'h80);
    preload(32'h40, 8'h01); preload(32'h41, 8'h02);
    preload(32'h42, 8'h03); preload(32'h43, 8'h04);
    preload(32'hFFFF_FFFF, 8'hAB); preload(32'h0, 8'hCD);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("reset_busy", 32'(mem_busy_o), 32'd0);
    chk("reset_ram_a", ram_a_o, 32'h0);
    chk("reset_mem_data", mem_data_o, 32'h0);

    // LW at 0x100
    issue(1, 0, 32'h100, 3'd4, 32'h0, 0, c0, last);
    goto_cyc(c0 + 5);
    chk("lw_no_early_enable", 32'(mem_enable_o), 32'd0);
    goto_cyc(c0 + 6);
    chk("lw_enable_c6", 32'(mem_enable_o), 32'd1);
    chk("lw_data", mem_data_o, 32'h4433_2211);
    goto_cyc(c0 + last + 1);

    // SH at 0x200
    issue(1, 1, 32'h200, 3'd2, 32'hDEAD_BEEF, 0, c0, last);
    goto_cyc(c0 + 2);
    chk("sh_c2_wr", 32'(ram_wr_o), 32'd1);
    chk("sh_c2_addr", ram_a_o, 32'h201);
    chk("sh_c2_byte", 32'(ram_dout_o), 32'hBE);
    goto_cyc(c0 + 3);
    chk("sh_enable_c3", 32'(mem_enable_o), 32'd1);
    goto_cyc(c0 + 4);
    chk("sh_ram_202_kept", 32'(ram_rd(32'h202)), 32'h77);
    chk("sh_ram_200", 32'(ram_rd(32'h200)), 32'hEF);

    // Simultaneous requests; fetch held high while busy, served afterwards
    if_require_i = 1'b1;
    if_addr_i = 32'h40;
    issue(1, 0, 32'h10, 3'd1, 32'h0, 0, c0, last);
    goto_cyc(c0 + 3);
    chk("arb_mem_enable_c3", 32'(mem_enable_o), 32'd1);
    chk("arb_mem_data", mem_data_o, 32'h0000_0080);
    chk("arb_if_enable_c3", 32'(if_enable_o), 32'd0);
    goto_cyc(c0 + 4);
    issue(0, 0, 32'h40, 3'd4, 32'h0, 0, c1, last);
    goto_cyc(c0 + 10);
    chk("arb_if_enable_c10", 32'(if_enable_o), 32'd1);
    chk("arb_if_data", if_data_o, 32'h0403_0201);
    goto_cyc(c1 + last + 1);

    // Reset during cycle 2 of an SW
    issue(1, 1, 32'h300, 3'd4, 32'hCAFE_F00D, 2, c0, last);
    goto_cyc(c0 + 2);
    rst = 1'b1;
    goto_cyc(c0 + 3);
    rst = 1'b0;
    chk("abort_ram_wr", 32'(ram_wr_o), 32'd0);
    chk("abort_ram_302", 32'(ram_rd(32'h302)), 32'(dflt(32'h302)));
    issue(1, 0, 32'h300, 3'd1, 32'h0, 0, c1, last);
    goto_cyc(c1 + 3);
    chk("abort_next_lb", mem_data_o, 32'h0000_000D);
    goto_cyc(c1 + last + 1);

    // LH across the address wrap
    issue(1, 0, 32'hFFFF_FFFF, 3'd2, 32'h0, 0, c0, last);
    goto_cyc(c0 + 1);
    chk("wrap_addr_c1", ram_a_o, 32'hFFFF_FFFF);
    goto_cyc(c0 + 2);
    chk("wrap_addr_c2", ram_a_o, 32'h0);
    goto_cyc(c0 + 4);
    chk("wrap_data", mem_data_o, 32'h0000_CDAB);
    goto_cyc(c0 + last + 1);

    // Illegal length 3 behaves as a word
    issue(1, 0, 32'h100, 3'b011, 32'h0, 0, c0, last);
    goto_cyc(c0 + 5);
    chk("len3_no_enable_c5", 32'(mem_enable_o), 32'd0);
    goto_cyc(c0 + 6);
    chk("len3_enable_c6", 32'(mem_enable_o), 32'd1);
    chk("len3_data", mem_data_o, 32'h4433_2211);
    goto_cyc(c0 + last + 1);

    // Random traffic, back-to-back or with short gaps
    for (int t = 0; t < 150; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      is_mem = ($urandom_range(0, 4) != 0);
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 31)))
                                      : (32'h1000 + 32'($urandom_range(0, 63)));
      issue(is_mem, 1'($urandom), a, 3'($urandom_range(0, 7)), $urandom, 0, c0, last);
      goto_cyc(c0 + last + 1);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller that sits directly downstream of the mem stage and of instruction fetch.
- Arbitrates their requests onto a single byte-wide synchronous RAM port.
- Serialises 1/2/4-byte loads and stores and 4-byte fetches into byte accesses.
- Returns results through a busy/enable handshake: busy = do not request; enable = one-cycle completion pulse with data.

Parameters:
- ADDR_W, 32, width of all address ports; RAM address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_require_i  in  1  fetch request, sampled only while idle.
- if_addr_i  in  ADDR_W  fetch address, always 4 bytes.
- if_busy_o  out  1  controller not idle.
- if_enable_o  out  1  one-cycle fetch completion pulse.
- if_data_o  out  32  fetched word.
- mem_require_i  in  1  mem-stage request, sampled only while idle.
- mem_wr_i  in  1  1 = write, 0 = read.
- mem_addr_i  in  ADDR_W  byte address.
- mem_length_i  in  3  byte count: 1, 2 or 4.
- mem_data_i  in  32  store data, low bytes used.
- mem_busy_o  out  1  controller not idle.
- mem_enable_o  out  1  one-cycle mem completion pulse.
- mem_data_o  out  32  load data, zero-extended; sign extension is done by the mem stage.
- ram_din_i  in  8  RAM read byte, valid the cycle after its address.
- ram_dout_o  out  8  RAM write byte.
- ram_a_o  out  ADDR_W  RAM address.
- ram_wr_o  out  1  RAM write strobe.

Behaviour:
- Reset: one clock; reset is synchronous and active-high on rst. At the reset edge, state goes to IDLE and all outputs go to 0 (busy, enable, data, ram_a_o, ram_dout_o, ram_wr_o).
- Reset mid-transaction: the transaction is aborted at that edge. No enable pulse is produced and ram_wr_o is low from the next cycle on.
- States: IDLE, READ, WRITE, DONE. Busy outputs = (state != IDLE), including the DONE cycle.
- Acceptance: a request is sampled only in IDLE.
  - If mem_require_i and if_require_i are both high, mem wins; fetch stays unserved and the requester re-requests once busy drops.
  - On acceptance, latch owner, wr, addr, length and data; requesters drop require while busy.
- Length rule: 1, 2 or 4 gives N = that value. Any other value (0, 3, 5-7) is treated as N = 4. Fetch uses N = 4.
- Cycle numbering: request sampled in cycle 0.
- READ:
  - Cycles 1..N: ram_a_o = addr + (k-1), ram_wr_o = 0.
  - In cycles 2..N+1, ram_din_i is captured into byte k-2 (little-endian: byte j goes to data[8j+7:8j]); upper unused bytes are 0.
  - Cycle N+2 = DONE: the owner's enable is high for exactly one cycle with data valid. LW enable in cycle 6; LB in cycle 3.
- WRITE (mem only):
  - Cycles 1..N: ram_wr_o = 1, ram_a_o = addr + (k-1), ram_dout_o = mem_data byte k-1.
  - Cycle N+1 = DONE: mem_enable_o pulses. SW in cycle 5; SB in cycle 2.
- A fetch with mem_wr_i high is impossible; fetch is always a read.
- After DONE: state returns to IDLE in the next cycle, where a new request may be accepted (back-to-back, one idle cycle minimum). Only the owner's enable pulses; the other enable stays 0.
- Data outputs: registered, and hold their last value until the owner's next completion.
- Idle outputs: ram_wr_o = 0, ram_a_o = 0, ram_dout_o = 0.
- Address wrap: addr + k wraps at 2^ADDR_W (0xFFFFFFFF + 1 = 0x0).

Decomposition:
- Length encodings (LEN_B = 3'b001, LEN_H = 3'b010, LEN_W = 3'b100) go in the shared defines header alongside RegBus/MemBus.
- The state encoding stays local to this module.
- No sub-module: arbitration and byte sequencing are one FSM with a 2-bit byte counter and a 32-bit assembly register.

Test Plan:
- LW: mem_require=1, addr=0x100, RAM holds 0x11,0x22,0x33,0x44 -> ram_a 0x100..0x103 in cycles 1-4; mem_enable only in cycle 6; mem_data_o=0x44332211.
- SH: addr=0x200, data=0xDEADBEEF -> ram_wr=1 in cycles 1-2 with (0x200,0xEF),(0x201,0xBE); mem_enable cycle 3; RAM unchanged at 0x202.
- Simultaneous if_require and mem_require (LB at 0x10, RAM[0x10]=0x80) -> mem served first; mem_data_o=0x00000080 in cycle 3; IF re-requests in cycle 4 and is served with if_enable in cycle 10.
- Reset asserted in cycle 2 of an SW -> ram_wr_o=0 from cycle 3; no enable ever; next request accepted normally.
- LH at addr 0xFFFFFFFF -> addresses 0xFFFFFFFF then 0x00000000.
- mem_length_i=3'b011 -> 4 bytes transferred; enable in cycle 6.
